instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder
// Streams instruction requests into RV64-style 32-bit encodings and writes
// them to consecutive instruction-memory words, one word per accepted request.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start, base_addr  session start pulse and first word address (IDLE only)
//   req_valid/ready   request handshake; a request transfers on any rising
//                     edge where req_valid && req_ready. req_ready is high
//                     only in RUN, independent of req_valid.
//   req_kind, req_sub instruction kind (0 LD .. 6 JAL, 7 illegal) and variant
//   rd, rs1, rs2, imm register fields and two's complement immediate
//   req_last          marks the final request of the session
//   imem_we/addr/wdata registered memory write, valid the cycle after the
//                     accepting edge
//   busy, done        busy in RUN/DONE; done pulses with the last write
//   err               sticky error flag, cleared by the next start
//   count             words written in the current session
//   dbg_state         current FSM state (0 IDLE, 1 RUN, 2 DONE)
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  base_addr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_kind,
  input  logic [2:0]  req_sub,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [20:0] imm,
  input  logic        req_last,
  output logic        imem_we,
  output logic [9:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [10:0] count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_LD     = 7'b0000011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t      state, state_next;
  logic [9:0]  ptr;
  logic        hs;
  logic        wrap;
  logic [31:0] enc_word;
  logic        enc_bad;

  // Immediate range checks: the upper bits beyond the format width must all
  // be copies of the format's sign bit.
  logic fits12, fits13;
  assign fits12 = (imm[20:11] == 10'h000) || (imm[20:11] == 10'h3ff);
  assign fits13 = (imm[20:12] == 9'h000)  || (imm[20:12] == 9'h1ff);

  assign req_ready = (state == S_RUN);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;
  assign hs        = req_valid && req_ready;
  // Writing the top word without req_last would run off the end of memory.
  assign wrap      = (ptr == 10'h3ff) && !req_last;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_RUN;
      S_RUN:  if (hs && (req_last || ptr == 10'h3ff)) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Encoder. LD/ADDI/JALR/JAL have no variants, so req_sub is ignored there.
  always_comb begin
    enc_word = NOP;
    enc_bad  = 1'b0;
    case (req_kind)
      3'd0: begin
        enc_word = {imm[11:0], rs1, 3'b011, rd, OP_LD};
        enc_bad  = !fits12;
      end
      3'd1: begin
        enc_word = {imm[11:0], rs1, 3'b000, rd, OP_ADDI};
        enc_bad  = !fits12;
      end
      3'd2: begin
        case (req_sub)
          3'd0: enc_word = {imm[11:5], rs2, rs1, 3'b011, imm[4:0], OP_STORE};
          3'd1: enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
          3'd2: enc_word = {imm[11:5], rs2, rs1, 3'b001, imm[4:0], OP_STORE};
          default: enc_word = NOP;
        endcase
        enc_bad = (req_sub > 3'd2) || !fits12;
      end
      3'd3: begin
        case (req_sub)
          3'd0: enc_word = {7'b0000000, rs2, rs1, 3'b000, rd, OP_RTYPE};
          3'd1: enc_word = {7'b0100000, rs2, rs1, 3'b000, rd, OP_RTYPE};
          3'd2: enc_word = {7'b0000000, rs2, rs1, 3'b111, rd, OP_RTYPE};
          3'd3: enc_word = {7'b0000000, rs2, rs1, 3'b110, rd, OP_RTYPE};
          3'd4: enc_word = {7'b0000000, rs2, rs1, 3'b100, rd, OP_RTYPE};
          3'd5: enc_word = {7'b0000000, rs2, rs1, 3'b010, rd, OP_RTYPE};
          default: enc_word = NOP;
        endcase
        enc_bad = (req_sub > 3'd5);
      end
      3'd4: begin
        case (req_sub)
          3'd0: enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b000,
                            imm[4:1], imm[11], OP_BRANCH};
          3'd1: enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b001,
                            imm[4:1], imm[11], OP_BRANCH};
          default: enc_word = NOP;
        endcase
        enc_bad = (req_sub > 3'd1) || !fits13 || imm[0];
      end
      3'd5: begin
        enc_word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
        enc_bad  = !fits12;
      end
      3'd6: begin
        // The 21-bit input always fits the J range; only odd offsets are bad.
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        enc_bad  = imm[0];
      end
      default: begin
        enc_word = NOP;
        enc_bad  = 1'b1;
      end
    endcase
  end

  // Datapath: pointer, count, error flag and the registered write port.
  // imem_addr/imem_wdata only change on a write, so they hold the last
  // written word through IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      count      <= '0;
      err        <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= hs;
      if (state == S_IDLE && start) begin
        ptr   <= base_addr;
        count <= '0;
        err   <= 1'b0;
      end
      if (hs) begin
        imem_addr  <= ptr;
        imem_wdata <= enc_word;
        ptr        <= ptr + 10'd1;
        count      <= count + 11'd1;
        if (enc_bad || wrap) err <= 1'b1;
      end
    end
  end

endmodule
